// File: rtl/ksa_pipe.sv
// ksa_pipe: parametrised, pipelined Kogge-Stone adder with valid/ready
// handshake and a sideband tag carried alongside every operation.
//
// Computes sum = (a + b + cin) mod 2^WIDTH and the carry out of the MSB.
// Stage 0 registers bitwise generate/propagate (cin folded into bit 0).
// After that, a register follows every REG_EVERY prefix levels. The last
// group of levels feeds the sum XOR directly into the output register.
// Latency is ceil(L/REG_EVERY) + 1 cycles, where L = ceil(log2(WIDTH)).
//
// Flow control is a global stall: every stage loads when the output
// register is empty or being drained (adv), and holds otherwise.
//
// Parameters:
//   WIDTH     operand/sum width (>= 2)
//   REG_EVERY prefix levels per pipeline register (>= 1)
//   TAG_W     sideband tag width (>= 1)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = adv)
//   a, b, cin, in_tag   operands, carry-in and tag
//   sub                 (KSA_SUB_EN only) 1 = compute a - b
//   out_valid/out_ready output handshake
//   sum, carryout       result and carry out of bit WIDTH-1
//   out_tag             tag of the result currently on sum
//
// Optional feature macro: KSA_SUB_EN adds the sub port. With sub=1 the
// adder sees ~b with carry-in 1; carryout=1 then means a >= b (no borrow).

module ksa_pipe #(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef KSA_SUB_EN
    input  logic             sub,
`endif
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L    = $clog2(WIDTH);
    localparam int NSTG = (L + REG_EVERY - 1) / REG_EVERY;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_g0_fold;

    // Prefix-stage registers; index 0 is the bitwise stage.
    logic [NSTG-1:0]            r_v;
    logic [NSTG-1:0][TAG_W-1:0] r_tag;
    logic [NSTG-1:0][WIDTH-1:0] r_g;
    logic [NSTG-1:0][WIDTH-1:0] r_pg;
    logic [NSTG-1:0][WIDTH-1:0] r_p;
    logic [NSTG-1:0]            r_cin;

    // Next-state values for each prefix-stage register.
    logic [NSTG-1:0]            w_nv;
    logic [NSTG-1:0][TAG_W-1:0] w_ntag;
    logic [NSTG-1:0][WIDTH-1:0] w_ng;
    logic [NSTG-1:0][WIDTH-1:0] w_npg;
    logic [NSTG-1:0][WIDTH-1:0] w_np;
    logic [NSTG-1:0]            w_ncin;

    // Per-level prefix inputs (w_ig/w_ip) and outputs (w_lg/w_lp).
    logic [L:1][WIDTH-1:0] w_ig;
    logic [L:1][WIDTH-1:0] w_ip;
    logic [L:1][WIDTH-1:0] w_lg;
    logic [L:1][WIDTH-1:0] w_lp;

    logic [WIDTH-1:0] w_sum;
    logic             w_unused;

    logic             r_ov;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [TAG_W-1:0] r_otag;

    assign w_adv    = !r_ov || out_ready;
    assign in_ready = w_adv;

`ifdef KSA_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    assign w_g0 = a & w_b_eff;
    assign w_p0 = a ^ w_b_eff;

    // cin acts as the generate of bit -1; merging it into bit 0 up front
    // lets L levels cover the full carry chain including the carry-in.
    assign w_g0_fold = {w_g0[WIDTH-1:1], w_g0[0] | (w_p0[0] & w_cin_eff)};

    assign w_nv[0]   = in_valid;
    assign w_ntag[0] = in_tag;
    assign w_ng[0]   = w_g0_fold;
    assign w_npg[0]  = w_p0;
    assign w_np[0]   = w_p0;
    assign w_ncin[0] = w_cin_eff;

    for (genvar s = 1; s < NSTG; s++) begin : g_stage
        assign w_nv[s]   = r_v[s-1];
        assign w_ntag[s] = r_tag[s-1];
        assign w_ng[s]   = w_lg[s*REG_EVERY];
        assign w_npg[s]  = w_lp[s*REG_EVERY];
        assign w_np[s]   = r_p[s-1];
        assign w_ncin[s] = r_cin[s-1];
    end

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int SPAN = 1 << (k - 1);

        // First level of each group starts from a register, the rest chain
        // combinationally from the previous level.
        if ((k - 1) % REG_EVERY == 0) begin : g_from_reg
            assign w_ig[k] = r_g[(k-1)/REG_EVERY];
            assign w_ip[k] = r_pg[(k-1)/REG_EVERY];
        end else begin : g_from_comb
            assign w_ig[k] = w_lg[k-1];
            assign w_ip[k] = w_lp[k-1];
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= SPAN) begin : g_dot
                assign w_lg[k][i] = w_ig[k][i] | (w_ip[k][i] & w_ig[k][i-SPAN]);
                assign w_lp[k][i] = w_ip[k][i] & w_ip[k][i-SPAN];
            end else begin : g_pass
                assign w_lg[k][i] = w_ig[k][i];
                assign w_lp[k][i] = w_ip[k][i];
            end
        end
    end

    // After the last level, w_lg[L][i] is the carry out of bit i.
    assign w_sum = r_p[NSTG-1] ^ {w_lg[L][WIDTH-2:0], r_cin[NSTG-1]};

    // Group propagate of the final level has no consumer.
    assign w_unused = ^w_lp[L];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= '0;
            r_tag  <= '0;
            r_g    <= '0;
            r_pg   <= '0;
            r_p    <= '0;
            r_cin  <= '0;
            r_ov   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_otag <= '0;
        end else if (w_adv) begin
            r_v    <= w_nv;
            r_tag  <= w_ntag;
            r_g    <= w_ng;
            r_pg   <= w_npg;
            r_p    <= w_np;
            r_cin  <= w_ncin;
            r_ov   <= r_v[NSTG-1];
            r_sum  <= w_sum;
            r_cout <= w_lg[L][WIDTH-1];
            r_otag <= r_tag[NSTG-1];
        end
    end

    assign out_valid = r_ov;
    assign sum       = r_sum;
    assign carryout  = r_cout;
    assign out_tag   = r_otag;

endmodule

// File: doc/ksa_pipe.md
Name: ksa_pipe

Overview:
Parametrised, pipelined Kogge-Stone adder. It is the successor to the fixed 8-bit combinational KSA.
- Generalised width; carry-in added.
- Configurable register placement between prefix levels.
- Valid/ready handshake on both sides, with a sideband tag that travels alongside the data.
- Sits in datapaths that need a high-Fmax add at one result per cycle.

Parameters:
WIDTH, 16, operand/sum width in bits; any value >= 2.
REG_EVERY, 1, pipeline register after every REG_EVERY prefix levels; value >= 1.
TAG_W, 4, width of the sideband tag passed through with each operation; value >= 1.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands presented.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
carryout  output  1  carry out of bit WIDTH-1.
out_tag  output  TAG_W  tag of the result currently on sum.

Behaviour:
- Prefix structure: L = ceil(log2(WIDTH)) Kogge-Stone levels. Span at level k is 2^(k-1). Use the standard (G,P) dot operator.
  - cin is folded in as generate of bit -1.
- Pipeline stages:
  - Stage 0 registers the bitwise G=a&b and P=a^b, plus cin.
  - After that, one register after every REG_EVERY prefix levels; the last group may be partial.
  - The final stage computes sum = P ^ carries and registers sum and carryout.
- Latency: LAT = ceil(L/REG_EVERY) + 1 cycles from the accept edge to out_valid. Example: WIDTH=8, REG_EVERY=1 gives LAT=4.
- Per-stage valid bit: a valid bit and the tag are carried in every stage.
- Flow control (global stall):
  - adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - All stages load on adv and hold otherwise.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Bubbles: a cycle with in_valid=0 while adv=1 inserts a bubble (valid=0). Bubbles are not compressed.
- While out_valid=1 and out_ready=0: sum, carryout and out_tag are held stable, and no stage changes.
- Ordering: results emerge in acceptance order. Throughput is 1 per cycle when out_ready is held high.
- Reset:
  - Clears all stage valid bits.
  - out_valid=0, sum=0, carryout=0, out_tag=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards every in-flight operation; none appear afterwards.
  - in_valid during reset is ignored.
- Simultaneous events: an output transfer and an input transfer in the same cycle are both honoured; the pipeline shifts by one.
- Data registers of invalid stages may hold any value, but out_* outputs are driven only from the last stage. The value required at reset is 0.

Optional Feature:
Macro KSA_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled with a.
  - When sub=1, B is replaced by ~b and carry-in is forced to 1, so sum = a - b mod 2^WIDTH. cin is ignored.
  - carryout = 1 means no borrow (a >= b unsigned).
  - sub travels only to stage 0; latency is unchanged.
- Not defined: port sub is absent and the block performs addition only, as described above.

Test Plan:
1. Reset with WIDTH=8, REG_EVERY=1 -> on the cycle after rst deasserts: out_valid=0, sum=0x00, carryout=0, out_tag=0, in_ready=1.
2. Single op a=0x08, b=0x01, cin=0, tag=3, out_ready=1 -> exactly 4 cycles later out_valid=1, sum=0x09, carryout=0, out_tag=3; out_valid low on the next cycle.
3. Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, carryout=1; then a=0xFF, b=0x00, cin=1 -> sum=0x00, carryout=1, on consecutive cycles.
4. Streaming: all 65536 (a,b) pairs with random cin, out_ready=1 -> one result per cycle, in order, matching a reference model; tags increment mod 16.
5. Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, and outputs are stable during those cycles; after release, no dropped or duplicated results. Random out_ready over 1000 ops -> scoreboard clean.
6. Reset mid-stream with 3 ops in flight -> out_valid=0 next cycle and no stale results afterwards. With KSA_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, carryout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, carryout=1.
